// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display multiplexer:
// FSM encoding, glyph codes, active-low segment patterns, BCD helpers.
package temp_disp_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned TEMP_W     = 8;
    localparam int unsigned MAG_W      = 7;
    localparam int unsigned BCD_W      = 10;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned GLYPH_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned OVR_LIMIT  = 99;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Glyph codes carried in the display registers
    localparam logic [GLYPH_W-1:0] GL_0     = 4'h0;
    localparam logic [GLYPH_W-1:0] GL_1     = 4'h1;
    localparam logic [GLYPH_W-1:0] GL_2     = 4'h2;
    localparam logic [GLYPH_W-1:0] GL_3     = 4'h3;
    localparam logic [GLYPH_W-1:0] GL_4     = 4'h4;
    localparam logic [GLYPH_W-1:0] GL_5     = 4'h5;
    localparam logic [GLYPH_W-1:0] GL_6     = 4'h6;
    localparam logic [GLYPH_W-1:0] GL_7     = 4'h7;
    localparam logic [GLYPH_W-1:0] GL_8     = 4'h8;
    localparam logic [GLYPH_W-1:0] GL_9     = 4'h9;
    localparam logic [GLYPH_W-1:0] GL_BLANK = 4'hA;
    localparam logic [GLYPH_W-1:0] GL_MINUS = 4'hB;
    localparam logic [GLYPH_W-1:0] GL_H     = 4'hC;
    localparam logic [GLYPH_W-1:0] GL_I     = 4'hD;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_I     = 7'b1111001;

    // One glyph per physical digit
    typedef struct packed {
        logic [GLYPH_W-1:0] sign;
        logic [GLYPH_W-1:0] tens;
        logic [GLYPH_W-1:0] ones;
    } disp_t;

    // Double-dabble nibble correction: add 3 when the nibble is 5 or more
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // One double-dabble step: correct tens/ones nibbles, then shift the next bit in.
    // Hundreds never exceeds 1 for a 7-bit magnitude, so it needs no correction.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] acc,
                                                 input logic              bit_in);
        logic [BCD_W-1:0] adj;
        adj = {acc[9:8], dd_adjust(acc[7:4]), dd_adjust(acc[3:0])};
        return {adj[BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/temp_display_mux_seg7_decode.sv
// Combinational glyph-code to active-low seven-segment decoder.
module temp_display_mux_seg7_decode
    import temp_disp_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    output logic [SEG_W-1:0]   seg_c
);

    // Map glyph code to segment pattern; unknown codes blank the digit
    always_comb begin
        seg_c = SEG_BLANK;
        case (glyph)
            GL_0:     seg_c = SEG_0;
            GL_1:     seg_c = SEG_1;
            GL_2:     seg_c = SEG_2;
            GL_3:     seg_c = SEG_3;
            GL_4:     seg_c = SEG_4;
            GL_5:     seg_c = SEG_5;
            GL_6:     seg_c = SEG_6;
            GL_7:     seg_c = SEG_7;
            GL_8:     seg_c = SEG_8;
            GL_9:     seg_c = SEG_9;
            GL_BLANK: seg_c = SEG_BLANK;
            GL_MINUS: seg_c = SEG_MINUS;
            GL_H:     seg_c = SEG_H;
            GL_I:     seg_c = SEG_I;
            default:  seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/temp_display_mux.sv
// Temperature display multiplexer: converts the signed sensor byte to BCD
// with a sequential double-dabble and drives three time-multiplexed
// common-anode digits (sign, tens, ones).
// Optional build macro LZ_BLANK_EN: blank a leading-zero tens digit.
module temp_display_mux
    import temp_disp_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
)
(
    input  logic               SYSCLK,
    input  logic               RST,
    input  logic [TEMP_W-1:0]  temp_in,
    input  logic               temp_valid,
    output logic [SEG_W-1:0]   seg,
    output logic [2:0]         an,
    output logic               busy,
    output logic               overrange
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned IDX_LAST  = NUM_DIGITS - 1;
    localparam int unsigned STEP_LAST = MAG_W - 1;

    state_t              state_q, state_d;
    logic [TEMP_W-1:0]   cap_q, cap_d;
    logic [MAG_W-1:0]    shf_q, shf_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                pend_vld_q, pend_vld_d;
    logic [TEMP_W-1:0]   pend_q, pend_d;
    disp_t               disp_q, disp_d;
    logic                ovr_d;
    logic                busy_d;
    logic                start_c;
    logic [TEMP_W-1:0]   start_val_c;

    disp_t               load_disp_c;
    logic                load_ovr_c;
    logic [MAG_W-1:0]    mag_c;

    logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
    logic [2:0]          an_d;
    logic [GLYPH_W-1:0]  sel_glyph_c;
    logic [SEG_W-1:0]    sel_seg_c;

    // Display values produced when a finished conversion is loaded
    always_comb begin
        mag_c       = cap_q[MAG_W-1:0];
        load_ovr_c  = (mag_c > MAG_W'(OVR_LIMIT));
        load_disp_c = '{sign: GL_BLANK, tens: GL_BLANK, ones: GL_BLANK};
        if (cap_q[TEMP_W-1] && (mag_c != '0)) begin
            load_disp_c.sign = GL_MINUS;
        end
        if (load_ovr_c) begin
            load_disp_c.tens = GL_H;
            load_disp_c.ones = GL_I;
        end else begin
            load_disp_c.tens = acc_q[7:4];
            load_disp_c.ones = acc_q[3:0];
`ifdef LZ_BLANK_EN
            if (acc_q[7:4] == GL_0) begin
                load_disp_c.tens = GL_BLANK;
            end
`endif
        end
    end

    // Conversion FSM next-state and datapath
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        shf_d       = shf_q;
        acc_d       = acc_q;
        step_d      = step_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        disp_d      = disp_q;
        ovr_d       = overrange;
        busy_d      = busy;
        start_c     = 1'b0;
        start_val_c = temp_in;

        case (state_q)
            IDLE: begin
                if (temp_valid) begin
                    start_c     = 1'b1;
                    start_val_c = temp_in;
                end
            end
            SHIFT: begin
                acc_d  = dd_step(acc_q, shf_q[MAG_W-1]);
                shf_d  = {shf_q[MAG_W-2:0], 1'b0};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(STEP_LAST)) begin
                    state_d = LOAD;
                end
                if (temp_valid) begin
                    pend_vld_d = 1'b1;
                    pend_d     = temp_in;
                end
            end
            LOAD: begin
                disp_d     = load_disp_c;
                ovr_d      = load_ovr_c;
                pend_vld_d = 1'b0;
                // A strobe coinciding with LOAD is newer than any pending value
                if (temp_valid) begin
                    start_c     = 1'b1;
                    start_val_c = temp_in;
                end else if (pend_vld_q) begin
                    start_c     = 1'b1;
                    start_val_c = pend_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_c) begin
            state_d = SHIFT;
            cap_d   = start_val_c;
            shf_d   = start_val_c[MAG_W-1:0];
            acc_d   = '0;
            step_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // Conversion state and display registers
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            shf_q      <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            disp_q     <= '{sign: GL_BLANK, tens: GL_BLANK, ones: GL_BLANK};
            overrange  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            shf_q      <= shf_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            overrange  <= ovr_d;
            busy       <= busy_d;
        end
    end

    // Refresh counter, digit index and the digit selected for the next cycle
    always_comb begin
        ref_cnt_d = ref_cnt_q + CNT_W'(1);
        dig_idx_d = dig_idx_q;
        if (ref_cnt_q >= (REFRESH_DIV - 16'd1)) begin
            ref_cnt_d = '0;
            dig_idx_d = (dig_idx_q >= IDX_W'(IDX_LAST)) ? '0 : (dig_idx_q + IDX_W'(1));
        end

        an_d        = 3'b111;
        sel_glyph_c = GL_BLANK;
        case (dig_idx_d)
            2'd0: begin
                an_d        = 3'b110;
                sel_glyph_c = disp_q.ones;
            end
            2'd1: begin
                an_d        = 3'b101;
                sel_glyph_c = disp_q.tens;
            end
            2'd2: begin
                an_d        = 3'b011;
                sel_glyph_c = disp_q.sign;
            end
            default: begin
                an_d        = 3'b111;
                sel_glyph_c = GL_BLANK;
            end
        endcase
    end

    temp_display_mux_seg7_decode u_seg7_decode (
        .glyph (sel_glyph_c),
        .seg_c (sel_seg_c)
    );

    // Digit enables and segments update on the same edge to avoid ghosting
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            ref_cnt_q <= '0;
            dig_idx_q <= '0;
            an        <= 3'b111;
            seg       <= SEG_BLANK;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            dig_idx_q <= dig_idx_d;
            an        <= an_d;
            seg       <= sel_seg_c;
        end
    end

endmodule

// File: tb/tb_temp_display_mux.sv
// Scoreboard bench for temp_display_mux: stimulus queues expected display
// results, a monitor checks each completed conversion against the queue.
module tb_temp_display_mux;

    localparam logic [15:0] DIV = 16'd3;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_MI = 7'b0111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_7  = 7'b1111000;
    localparam logic [6:0] S_9  = 7'b0010000;
    localparam logic [6:0] S_H  = 7'b0001001;
    localparam logic [6:0] S_I  = 7'b1111001;
`ifdef LZ_BLANK_EN
    localparam logic [6:0] S_LZ = S_BL;
`else
    localparam logic [6:0] S_LZ = S_0;
`endif

    typedef struct packed {
        logic [7:0] tag;
        logic [6:0] sg;
        logic [6:0] tn;
        logic [6:0] on;
        logic       ovr;
        logic [7:0] blen;
    } exp_t;

    logic       SYSCLK;
    logic       RST;
    logic [7:0] temp_in;
    logic       temp_valid;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;
    logic       overrange;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    logic mon_busy;

    temp_display_mux #(.REFRESH_DIV(DIV)) dut (
        .SYSCLK     (SYSCLK),
        .RST        (RST),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .overrange  (overrange)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Wait for a given digit enable and return the segments shown with it
    task automatic collect(input logic [2:0] tgt, output logic [6:0] s_o, output logic ok);
        ok  = 1'b0;
        s_o = 7'h00;
        for (int i = 0; i < 24; i++) begin
            @(negedge SYSCLK);
            if (an === tgt) begin
                s_o = seg;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_slots(input string nm, input logic [6:0] sg, input logic [6:0] tn,
                               input logic [6:0] on);
        logic [6:0] s;
        logic       ok;
        collect(3'b011, s, ok);
        if (!ok) check({nm, "_sign_timeout"}, 32'(ok), 32'd1);
        else     check({nm, "_sign"}, 32'(s), 32'(sg));
        collect(3'b101, s, ok);
        if (!ok) check({nm, "_tens_timeout"}, 32'(ok), 32'd1);
        else     check({nm, "_tens"}, 32'(s), 32'(tn));
        collect(3'b110, s, ok);
        if (!ok) check({nm, "_ones_timeout"}, 32'(ok), 32'd1);
        else     check({nm, "_ones"}, 32'(s), 32'(on));
    endtask

    task automatic push(input logic [7:0] tag, input logic [6:0] sg, input logic [6:0] tn,
                        input logic [6:0] on, input logic ovr, input logic [7:0] blen);
        exp_t e;
        e.tag  = tag;
        e.sg   = sg;
        e.tn   = tn;
        e.on   = on;
        e.ovr  = ovr;
        e.blen = blen;
        sb_q.push_back(e);
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge SYSCLK);
        temp_in    = v;
        temp_valid = 1'b1;
        @(negedge SYSCLK);
        temp_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(posedge SYSCLK);
            if (sb_q.size() == 0 && !mon_busy) return;
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: a busy fall marks a completed result; check it against the queue head
    initial begin
        int         run;
        exp_t       e;
        run      = 0;
        mon_busy = 1'b0;
        forever begin
            @(negedge SYSCLK);
            if (RST) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run > 0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(run), 32'd0);
                    run = 0;
                end else begin
                    mon_busy = 1'b1;
                    e = sb_q.pop_front();
                    check($sformatf("busy_len_%02h", e.tag), 32'(run), 32'(e.blen));
                    check($sformatf("overrange_%02h", e.tag), 32'(overrange), 32'(e.ovr));
                    run = 0;
                    @(posedge SYSCLK);
                    check_slots($sformatf("disp_%02h", e.tag), e.sg, e.tn, e.on);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        RST        = 1'b1;
        temp_in    = 8'h00;
        temp_valid = 1'b0;
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_an", 32'(an), 32'b111);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovr", 32'(overrange), 32'd0);
        RST = 1'b0;
        check_slots("post_reset", S_BL, S_BL, S_BL);

        push(8'h19, S_BL, S_2, S_5, 1'b0, 8'd8);
        pulse(8'h19);
        wait_done();

        push(8'h87, S_MI, S_LZ, S_7, 1'b0, 8'd8);
        pulse(8'h87);
        wait_done();

        push(8'h80, S_BL, S_LZ, S_0, 1'b0, 8'd8);
        pulse(8'h80);
        wait_done();

        push(8'h7F, S_BL, S_H, S_I, 1'b1, 8'd8);
        pulse(8'h7F);
        wait_done();

        push(8'h63, S_BL, S_9, S_9, 1'b0, 8'd8);
        pulse(8'h63);
        wait_done();

        push(8'hE3, S_MI, S_9, S_9, 1'b0, 8'd8);
        pulse(8'hE3);
        wait_done();

        push(8'hE4, S_MI, S_H, S_I, 1'b1, 8'd8);
        pulse(8'hE4);
        wait_done();

        // Reset four edges into a conversion: nothing of 0x42 may appear
        pulse(8'h42);
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        RST = 1'b1;
        @(negedge SYSCLK);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_an", 32'(an), 32'b111);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovr", 32'(overrange), 32'd0);
        @(negedge SYSCLK);
        RST = 1'b0;
        repeat (12) @(negedge SYSCLK);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_idle_ovr", 32'(overrange), 32'd0);
        check_slots("midrst", S_BL, S_BL, S_BL);

        // Back-to-back: 10 then 20 three cycles later, busy held 16 cycles
        push(8'h14, S_BL, S_2, S_0, 1'b0, 8'd16);
        pulse(8'h0A);
        @(negedge SYSCLK);
        pulse(8'h14);
        wait_done();

        // Third strobe overwrites the pending 20 with 33
        push(8'h21, S_BL, S_3, S_3, 1'b0, 8'd16);
        pulse(8'h0A);
        @(negedge SYSCLK);
        pulse(8'h14);
        pulse(8'h21);
        wait_done();

        repeat (4) @(negedge SYSCLK);
        check("final_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
